// File: rtl/diode_request_sequencer_pkg.sv
// Shared state encodings and defaults for the diode request sequencer.
// No timing of its own; constants only.
package diode_request_sequencer_pkg;

  localparam int GUARD_CYCLES_DEF = 320;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/diode_request_sequencer_if.sv
// Trigger, burst configuration and status bundle between a controller and the sequencer.
// Pure wiring: no latency, no backpressure (requests are fire-and-forget pulses).
interface diode_request_sequencer_if #(
  parameter int PERIOD_W = 16,
  parameter int BURST_W  = 8
);
  logic                stm_signal_i;
  logic                enable_i;
  logic                abort_i;
  logic [PERIOD_W-1:0] period_i;
  logic [BURST_W-1:0]  burst_len_i;
  logic                signal_to_diods_request;
  logic                busy_o;
  logic                burst_done_o;
  logic                overrun_o;
  logic [BURST_W-1:0]  pulse_index_o;

  modport master (
    output stm_signal_i, enable_i, abort_i, period_i, burst_len_i,
    input  signal_to_diods_request, busy_o, burst_done_o, overrun_o, pulse_index_o
  );

  modport slave (
    input  stm_signal_i, enable_i, abort_i, period_i, burst_len_i,
    output signal_to_diods_request, busy_o, burst_done_o, overrun_o, pulse_index_o
  );
endinterface

// File: rtl/diode_request_sequencer_sync_edge_detect.sv
// Multi-flop synchroniser with a registered rising-edge pulse; pulse appears STAGES+1 edges
// after the input is first sampled high. No backpressure.
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_200MHz_i,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // History resets to RESET_VAL so a level already high at reset release is not an edge.
  always_ff @(posedge clk_200MHz_i or posedge reset) begin
    if (reset) begin
      chain      <= {STAGES{RESET_VAL}};
      prev       <= RESET_VAL;
      edge_pulse <= 1'b0;
    end else begin
      chain      <= {chain[STAGES-2:0], async_in};
      prev       <= chain[STAGES-1];
      edge_pulse <= chain[STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/diode_request_sequencer.sv
// Burst request sequencer: synchronised STM trigger -> N one-cycle requests spaced >= guard.
// Request lags trigger by SYNC_STAGES+2 edges; no backpressure, extra triggers flag overrun.
module diode_request_sequencer
  import diode_request_sequencer_pkg::*;
#(
  parameter int PERIOD_W     = 16,
  parameter int BURST_W      = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic                     clk_200MHz_i,
  input  logic                     reset,
  diode_request_sequencer_if.slave bus
);

  localparam logic [PERIOD_W-1:0] GUARD = PERIOD_W'(GUARD_CYCLES);

  logic                trig_edge;
  logic [1:0]          state;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] timer;
  logic [BURST_W-1:0]  len_q;
  logic [BURST_W-1:0]  index;
  logic [BURST_W-1:0]  index_nxt;
  logic [PERIOD_W-1:0] eff_period;
  logic [BURST_W-1:0]  eff_len;
  logic                stop_req;
  logic                request;
  logic                busy;
  logic                done;
  logic                overrun;

  sync_edge_detect #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_200MHz_i (clk_200MHz_i),
    .reset        (reset),
    .async_in     (bus.stm_signal_i),
    .edge_pulse   (trig_edge)
  );

  assign eff_period = (bus.period_i < GUARD) ? GUARD : bus.period_i;
  assign eff_len    = (bus.burst_len_i == '0) ? BURST_W'(1) : bus.burst_len_i;
  assign stop_req   = bus.abort_i | ~bus.enable_i;
  assign index_nxt  = index + BURST_W'(1);

  always_ff @(posedge clk_200MHz_i or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      period_q <= '0;
      timer    <= '0;
      len_q    <= '0;
      index    <= '0;
      request  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // Status outputs are a registered view of the state, so all of them lag it by one cycle.
      request <= (state == ST_FIRE);
      done    <= (state == ST_DONE);
      busy    <= (state != ST_IDLE);
      if (trig_edge && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (trig_edge && bus.enable_i) begin
            period_q <= eff_period;
            len_q    <= eff_len;
            index    <= '0;
            state    <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          index <= index_nxt;
          timer <= period_q - PERIOD_W'(1);
          if (stop_req) begin
            state <= ST_IDLE;
          end else if (index_nxt == len_q) begin
            state <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Leaving as the timer reaches zero makes FIRE + WAIT exactly one period long.
          if (stop_req) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer - PERIOD_W'(1);
            if (timer == PERIOD_W'(1)) begin
              state <= ST_FIRE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.signal_to_diods_request = request;
  assign bus.busy_o                  = busy;
  assign bus.burst_done_o            = done;
  assign bus.overrun_o               = overrun;
  assign bus.pulse_index_o           = index;

endmodule

// File: tb/tb_diode_request_sequencer.sv
// Directed bench for diode_request_sequencer: edge-numbered trigger scenarios with fixed expectations.
module tb_diode_request_sequencer;

  logic clk_200MHz_i = 1'b0;
  logic reset        = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int req_q[$];
  int done_q[$];
  int busy_rise;
  int busy_fall;
  logic busy_prev;

  diode_request_sequencer_if bus ();

  diode_request_sequencer dut (
    .clk_200MHz_i (clk_200MHz_i),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 clk_200MHz_i = ~clk_200MHz_i;

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    req_q.delete();
    done_q.delete();
    busy_rise = -1;
    busy_fall = -1;
    busy_prev = bus.busy_o;
  endtask

  // Advance n edges, sampling 1 time unit after each; cyc numbers the edge just sampled.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_200MHz_i);
      #1;
      if (bus.signal_to_diods_request === 1'b1) req_q.push_back(cyc);
      if (bus.burst_done_o === 1'b1) done_q.push_back(cyc);
      if (bus.busy_o === 1'b1 && busy_prev !== 1'b1 && busy_rise < 0) busy_rise = cyc;
      if (bus.busy_o !== 1'b1 && busy_prev === 1'b1 && busy_fall < 0) busy_fall = cyc;
      busy_prev = bus.busy_o;
      cyc++;
    end
  endtask

  // Raise the trigger mid-cycle so the next edge is edge 0.
  task automatic trigger();
    @(negedge clk_200MHz_i);
    bus.stm_signal_i = 1'b1;
    cyc = 0;
    clear_log();
  endtask

  task automatic release_trig();
    bus.stm_signal_i = 1'b0;
    run(6);
  endtask

  task automatic test_reset();
    bus.stm_signal_i = 1'b0;
    bus.enable_i     = 1'b1;
    bus.abort_i      = 1'b0;
    bus.period_i     = '0;
    bus.burst_len_i  = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk_200MHz_i);
    @(negedge clk_200MHz_i);
    reset = 1'b0;
    clear_log();
    run(5);
    vectors++; if (bus.signal_to_diods_request !== 1'b0) begin miscompares++; $display("FAIL rst_request got %b exp 0", bus.signal_to_diods_request); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", bus.busy_o); end
    vectors++; if (bus.burst_done_o !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b exp 0", bus.burst_done_o); end
    vectors++; if (bus.overrun_o !== 1'b0) begin miscompares++; $display("FAIL rst_overrun got %b exp 0", bus.overrun_o); end
    vectors++; if (bus.pulse_index_o !== 8'd0) begin miscompares++; $display("FAIL rst_index got %0d exp 0", bus.pulse_index_o); end
  endtask

  task automatic test_disabled();
    bus.enable_i    = 1'b0;
    bus.period_i    = 16'd320;
    bus.burst_len_i = 8'd1;
    trigger();
    run(30);
    vectors++; if (req_q.size() != 0) begin miscompares++; $display("FAIL dis_requests got %0d exp 0", req_q.size()); end
    vectors++; if (bus.overrun_o !== 1'b0) begin miscompares++; $display("FAIL dis_overrun got %b exp 0", bus.overrun_o); end
    vectors++; if (busy_rise != -1) begin miscompares++; $display("FAIL dis_busy got rise at %0d exp none", busy_rise); end
    bus.enable_i = 1'b1;
    release_trig();
  endtask

  task automatic test_basic_burst();
    bus.period_i    = 16'd1000;
    bus.burst_len_i = 8'd3;
    trigger();
    run(2010);
    vectors++; if (req_q.size() != 3) begin miscompares++; $display("FAIL t1_req_count got %0d exp 3", req_q.size()); end
    vectors++; if (qat(req_q, 0) != 4) begin miscompares++; $display("FAIL t1_req0 got %0d exp 4", qat(req_q, 0)); end
    vectors++; if (qat(req_q, 1) != 1004) begin miscompares++; $display("FAIL t1_req1 got %0d exp 1004", qat(req_q, 1)); end
    vectors++; if (qat(req_q, 2) != 2004) begin miscompares++; $display("FAIL t1_req2 got %0d exp 2004", qat(req_q, 2)); end
    vectors++; if (done_q.size() != 1 || qat(done_q, 0) != 2005) begin miscompares++; $display("FAIL t1_done got %0d (n=%0d) exp 2005", qat(done_q, 0), done_q.size()); end
    vectors++; if (busy_rise != 4) begin miscompares++; $display("FAIL t1_busy_rise got %0d exp 4", busy_rise); end
    vectors++; if (busy_fall != 2006) begin miscompares++; $display("FAIL t1_busy_fall got %0d exp 2006", busy_fall); end
    vectors++; if (bus.pulse_index_o !== 8'd3) begin miscompares++; $display("FAIL t1_index got %0d exp 3", bus.pulse_index_o); end
    vectors++; if (bus.overrun_o !== 1'b0) begin miscompares++; $display("FAIL t1_overrun got %b exp 0", bus.overrun_o); end
    release_trig();
  endtask

  task automatic test_guard_spacing();
    bus.period_i    = 16'd10;
    bus.burst_len_i = 8'd2;
    trigger();
    run(340);
    vectors++; if (req_q.size() != 2) begin miscompares++; $display("FAIL t2_req_count got %0d exp 2", req_q.size()); end
    vectors++; if (qat(req_q, 1) - qat(req_q, 0) != 320) begin miscompares++; $display("FAIL t2_spacing got %0d exp 320", qat(req_q, 1) - qat(req_q, 0)); end
    vectors++; if (qat(done_q, 0) != 325) begin miscompares++; $display("FAIL t2_done got %0d exp 325", qat(done_q, 0)); end
    release_trig();
  endtask

  task automatic test_zero_len();
    bus.period_i    = 16'd320;
    bus.burst_len_i = 8'd0;
    trigger();
    run(340);
    vectors++; if (req_q.size() != 1 || qat(req_q, 0) != 4) begin miscompares++; $display("FAIL t3_req got %0d (n=%0d) exp 4 (n=1)", qat(req_q, 0), req_q.size()); end
    vectors++; if (done_q.size() != 1 || qat(done_q, 0) != 5) begin miscompares++; $display("FAIL t3_done got %0d (n=%0d) exp 5 (n=1)", qat(done_q, 0), done_q.size()); end
    vectors++; if (bus.pulse_index_o !== 8'd1) begin miscompares++; $display("FAIL t3_index got %0d exp 1", bus.pulse_index_o); end
    release_trig();
  endtask

  task automatic test_overrun();
    bus.period_i    = 16'd400;
    bus.burst_len_i = 8'd3;
    trigger();
    run(20);
    // Config changes after acceptance must not affect the running burst.
    bus.period_i     = 16'd5;
    bus.burst_len_i  = 8'd9;
    bus.stm_signal_i = 1'b0;
    run(30);
    bus.stm_signal_i = 1'b1;
    run(770);
    vectors++; if (bus.overrun_o !== 1'b1) begin miscompares++; $display("FAIL t4_overrun got %b exp 1", bus.overrun_o); end
    vectors++; if (req_q.size() != 3) begin miscompares++; $display("FAIL t4_req_count got %0d exp 3", req_q.size()); end
    vectors++; if (qat(req_q, 2) != 804) begin miscompares++; $display("FAIL t4_req2 got %0d exp 804", qat(req_q, 2)); end
    vectors++; if (qat(done_q, 0) != 805) begin miscompares++; $display("FAIL t4_done got %0d exp 805", qat(done_q, 0)); end
    vectors++; if (bus.pulse_index_o !== 8'd3) begin miscompares++; $display("FAIL t4_index got %0d exp 3", bus.pulse_index_o); end
    release_trig();
  endtask

  task automatic test_abort();
    vectors++; if (bus.overrun_o !== 1'b1) begin miscompares++; $display("FAIL t5_overrun_sticky got %b exp 1", bus.overrun_o); end
    bus.period_i    = 16'd400;
    bus.burst_len_i = 8'd4;
    trigger();
    run(100);
    bus.abort_i = 1'b1;
    run(1);
    bus.abort_i = 1'b0;
    run(1500);
    vectors++; if (req_q.size() != 1) begin miscompares++; $display("FAIL t5_req_count got %0d exp 1", req_q.size()); end
    vectors++; if (done_q.size() != 0) begin miscompares++; $display("FAIL t5_done_count got %0d exp 0", done_q.size()); end
    vectors++; if (bus.pulse_index_o !== 8'd1) begin miscompares++; $display("FAIL t5_index got %0d exp 1", bus.pulse_index_o); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL t5_busy got %b exp 0", bus.busy_o); end
    release_trig();
    bus.period_i    = 16'd320;
    bus.burst_len_i = 8'd1;
    trigger();
    run(20);
    vectors++; if (req_q.size() != 1 || qat(req_q, 0) != 4) begin miscompares++; $display("FAIL t5_retrig_req got %0d (n=%0d) exp 4 (n=1)", qat(req_q, 0), req_q.size()); end
    vectors++; if (qat(done_q, 0) != 5) begin miscompares++; $display("FAIL t5_retrig_done got %0d exp 5", qat(done_q, 0)); end
    release_trig();
  endtask

  task automatic test_reset_behaviour();
    @(negedge clk_200MHz_i);
    bus.stm_signal_i = 1'b1;
    reset = 1'b1;
    run(3);
    @(negedge clk_200MHz_i);
    reset = 1'b0;
    cyc = 0;
    clear_log();
    run(50);
    vectors++; if (req_q.size() != 0) begin miscompares++; $display("FAIL t6_held_high_req got %0d exp 0", req_q.size()); end
    vectors++; if (bus.overrun_o !== 1'b0) begin miscompares++; $display("FAIL t6_overrun_cleared got %b exp 0", bus.overrun_o); end
    release_trig();
    bus.period_i    = 16'd320;
    bus.burst_len_i = 8'd2;
    trigger();
    run(100);
    vectors++; if (req_q.size() != 1 || qat(req_q, 0) != 4) begin miscompares++; $display("FAIL t6_burst_req got %0d (n=%0d) exp 4 (n=1)", qat(req_q, 0), req_q.size()); end
    vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL t6_busy_mid got %b exp 1", bus.busy_o); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL t6_rst_busy got %b exp 0", bus.busy_o); end
    vectors++; if (bus.pulse_index_o !== 8'd0) begin miscompares++; $display("FAIL t6_rst_index got %0d exp 0", bus.pulse_index_o); end
    vectors++; if (bus.signal_to_diods_request !== 1'b0 || bus.burst_done_o !== 1'b0) begin miscompares++; $display("FAIL t6_rst_req_done got %b%b exp 00", bus.signal_to_diods_request, bus.burst_done_o); end
    @(negedge clk_200MHz_i);
    reset = 1'b0;
    clear_log();
    run(400);
    vectors++; if (req_q.size() != 0) begin miscompares++; $display("FAIL t6_post_rst_req got %0d exp 0", req_q.size()); end
  endtask

  initial begin
    test_reset();
    test_disabled();
    test_basic_burst();
    test_guard_spacing();
    test_zero_len();
    test_overrun();
    test_abort();
    test_reset_behaviour();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
